adda_reset_seq: RTL and testbench

// - Consumer of the board power-on reset. Sequences release of the ADC-interface, DAC-interface and DSP-core resets.
// - Releases ADC first, then DAC, then DSP. Release starts only after the sampling PLL lock is debounced, with a fixed gap between stages.
// - Sits between the power-on reset generator, the register bank (which drives sw_rst_req) and the ADDA datapath.

---
 rtl/adda_reset_seq.sv | 181 ++++++++++++++++++
 tb/tb_adda_reset_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/adda_reset_seq.sv
// adda_reset_seq: sequences release of the ADC, DAC and DSP resets after a
// debounced sampling-PLL lock. ADC is released first, then DAC, then DSP,
// with a fixed gap between stages.
// Optional feature macro: RST_SEQ_WDOG_EN -- adds a lock-loss watchdog in RUN
// that sends the sequence back to HOLD and sets the sticky lock_lost flag.
module adda_reset_seq #(
  parameter int unsigned HOLD_LEN     = 16,
  parameter int unsigned DEB_LEN      = 16,
  parameter int unsigned STAGE_DLY    = 1000,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sw_rst_req,
  input  logic       pll_locked,
  output logic       adc_rst,
  output logic       dac_rst,
  output logic       dsp_rst,
  output logic       seq_done,
  output logic       seq_err,
  output logic       lock_lost,
  output logic [2:0] seq_state
);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_REL_ADC = 3'd2;
  localparam logic [2:0] S_REL_DAC = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_LEN - 1);
  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEB_LEN - 1);
  localparam logic [CNT_W-1:0] STG_END  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       sync_q;
  logic             lock_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic             adc_rst_q, adc_rst_d;
  logic             dac_rst_q, dac_rst_d;
  logic             dsp_rst_q, dsp_rst_d;
  logic             seq_done_q, seq_done_d;
  logic             seq_err_q, seq_err_d;
  logic             restart;

  // Two-flop synchroniser for the asynchronous PLL lock; left unreset on purpose
  always_ff @(posedge clock) begin
    sync_q <= {sync_q[0], pll_locked};
  end

  assign lock_s = sync_q[1];

`ifdef RST_SEQ_WDOG_EN
  logic lost_set;
  logic lock_lost_q, lock_lost_d;
`endif

  // Next-state logic; sw_rst_req overrides every state transition
  always_comb begin
    state_d = state_q;
`ifdef RST_SEQ_WDOG_EN
    lost_set = 1'b0;
`endif
    case (state_q)
      S_HOLD:    if (cnt_q == HOLD_END) state_d = S_WAIT;
      S_WAIT: begin
        // Lock takes priority over a timeout on the same edge
        if (lock_s && deb_q == DEB_END) state_d = S_REL_ADC;
        else if (cnt_q == TMO_END)      state_d = S_ERR;
      end
      S_REL_ADC: if (cnt_q == STG_END) state_d = S_REL_DAC;
      S_REL_DAC: if (cnt_q == STG_END) state_d = S_RUN;
      S_RUN: begin
`ifdef RST_SEQ_WDOG_EN
        if (!lock_s && deb_q == DEB_END) begin
          state_d  = S_HOLD;
          lost_set = 1'b1;
        end
`endif
      end
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_HOLD;
    endcase
    if (sw_rst_req) state_d = S_HOLD;
  end

  assign restart = sw_rst_req || (state_d != state_q);

  // Counters: both clear on any state change or restart, and saturate otherwise
  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    deb_d = '0;
    if (restart) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        // Lock debounce: consecutive synced-high cycles
        S_WAIT: if (lock_s) deb_d = (deb_q == CNT_MAX) ? deb_q : deb_q + 1'b1;
`ifdef RST_SEQ_WDOG_EN
        // Loss debounce: consecutive synced-low cycles
        S_RUN:  if (!lock_s) deb_d = (deb_q == CNT_MAX) ? deb_q : deb_q + 1'b1;
`endif
        default: deb_d = '0;
      endcase
    end
  end

  // Output decode from the next state so outputs move with seq_state
  always_comb begin
    adc_rst_d  = 1'b1;
    dac_rst_d  = 1'b1;
    dsp_rst_d  = 1'b1;
    seq_done_d = 1'b0;
    seq_err_d  = 1'b0;
    case (state_d)
      S_REL_ADC: adc_rst_d = 1'b0;
      S_REL_DAC: begin
        adc_rst_d = 1'b0;
        dac_rst_d = 1'b0;
      end
      S_RUN: begin
        adc_rst_d  = 1'b0;
        dac_rst_d  = 1'b0;
        dsp_rst_d  = 1'b0;
        seq_done_d = 1'b1;
      end
      S_ERR:   seq_err_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      deb_q      <= '0;
      adc_rst_q  <= 1'b1;
      dac_rst_q  <= 1'b1;
      dsp_rst_q  <= 1'b1;
      seq_done_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      adc_rst_q  <= adc_rst_d;
      dac_rst_q  <= dac_rst_d;
      dsp_rst_q  <= dsp_rst_d;
      seq_done_q <= seq_done_d;
      seq_err_q  <= seq_err_d;
    end
  end

`ifdef RST_SEQ_WDOG_EN
  assign lock_lost_d = lock_lost_q | lost_set;

  // Sticky lock-loss flag; only the system reset clears it
  always_ff @(posedge clock) begin
    if (reset) lock_lost_q <= 1'b0;
    else       lock_lost_q <= lock_lost_d;
  end

  assign lock_lost = lock_lost_q;
`else
  assign lock_lost = 1'b0;
`endif

  assign adc_rst   = adc_rst_q;
  assign dac_rst   = dac_rst_q;
  assign dsp_rst   = dsp_rst_q;
  assign seq_done  = seq_done_q;
  assign seq_err   = seq_err_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_adda_reset_seq.sv
// tb_adda_reset_seq: directed checks of the ADDA reset sequencer with
// HOLD_LEN=4, DEB_LEN=4, STAGE_DLY=8, LOCK_TIMEOUT=64.
// Edge E0 is the edge on which reset is released (the last edge that still
// resets the DUT); outputs are sampled 1 time unit after each rising edge.
module tb_adda_reset_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       pll_locked = 1'b0;
  logic       adc_rst, dac_rst, dsp_rst;
  logic       seq_done, seq_err, lock_lost;
  logic [2:0] seq_state;

  int checks = 0;
  int errs   = 0;
  int e      = 0;

  adda_reset_seq #(
    .HOLD_LEN(4), .DEB_LEN(4), .STAGE_DLY(8), .LOCK_TIMEOUT(64), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .sw_rst_req(sw_rst_req), .pll_locked(pll_locked),
    .adc_rst(adc_rst), .dac_rst(dac_rst), .dsp_rst(dsp_rst),
    .seq_done(seq_done), .seq_err(seq_err), .lock_lost(lock_lost),
    .seq_state(seq_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @E%0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic wait_to(input int k);
    while (e < k) step();
  endtask

  // Reset with the given lock level; leaves the bench just after E0
  task automatic do_reset(input logic pll);
    pll_locked = pll;
    sw_rst_req = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    e = 0;
  endtask

  function automatic logic [31:0] rsts();
    return {29'd0, adc_rst, dac_rst, dsp_rst};
  endfunction

  initial begin
    // ---- Test 1: lock held high, full release sequence
    do_reset(1'b1);
    chk("t1_rst_state", seq_state, 0);
    chk("t1_rst_rsts",  rsts(), 3'b111);
    chk("t1_rst_done",  seq_done, 0);
    chk("t1_rst_err",   seq_err, 0);
    chk("t1_rst_lost",  lock_lost, 0);
    wait_to(3);  chk("t1_e3_state", seq_state, 0);
    wait_to(4);  chk("t1_e4_state", seq_state, 1);
                 chk("t1_e4_rsts",  rsts(), 3'b111);
    wait_to(7);  chk("t1_e7_state", seq_state, 1);
    wait_to(8);  chk("t1_e8_state", seq_state, 2);
                 chk("t1_e8_rsts",  rsts(), 3'b011);
    wait_to(15); chk("t1_e15_state", seq_state, 2);
    wait_to(16); chk("t1_e16_state", seq_state, 3);
                 chk("t1_e16_rsts",  rsts(), 3'b001);
    wait_to(23); chk("t1_e23_done", seq_done, 0);
    wait_to(24); chk("t1_e24_state", seq_state, 4);
                 chk("t1_e24_rsts",  rsts(), 3'b000);
                 chk("t1_e24_done",  seq_done, 1);

    // ---- Test 4: sw_rst_req in RUN, plus a lock dip during REL_ADC (ignored)
    wait_to(27);
    sw_rst_req = 1'b1;
    step();  // E28 is the pulse edge
    sw_rst_req = 1'b0;
    chk("t4_p_state", seq_state, 0);
    chk("t4_p_rsts",  rsts(), 3'b111);
    chk("t4_p_done",  seq_done, 0);
    wait_to(36); chk("t4_rel_adc", seq_state, 2);
    wait_to(37); pll_locked = 1'b0;
    wait_to(39); pll_locked = 1'b1;
    wait_to(43); chk("t4_e43_state", seq_state, 2);
    wait_to(44); chk("t4_e44_state", seq_state, 3);
    wait_to(51); chk("t4_e51_state", seq_state, 3);
    wait_to(52); chk("t4_e52_state", seq_state, 4);
                 chk("t4_e52_done",  seq_done, 1);

    // ---- Test 3: lock glitch restarts the debounce
    do_reset(1'b0);
    wait_to(3); pll_locked = 1'b1;
    wait_to(6); pll_locked = 1'b0;
    wait_to(7); pll_locked = 1'b1;
    wait_to(9);  chk("t3_e9_state",  seq_state, 1);
    wait_to(12); chk("t3_e12_state", seq_state, 1);
                 chk("t3_e12_adc",   adc_rst, 1);
    wait_to(13); chk("t3_e13_state", seq_state, 2);
                 chk("t3_e13_adc",   adc_rst, 0);

    // Reset and sw_rst_req together: reset wins, same HOLD result
    wait_to(20);
    reset = 1'b1;
    sw_rst_req = 1'b1;
    step();
    reset = 1'b0;
    sw_rst_req = 1'b0;
    chk("both_state", seq_state, 0);
    chk("both_rsts",  rsts(), 3'b111);
    chk("both_lost",  lock_lost, 0);

    // ---- Test 2: no lock -> ERR after the timeout
    do_reset(1'b0);
    wait_to(67); chk("t2_e67_state", seq_state, 1);
                 chk("t2_e67_err",   seq_err, 0);
    wait_to(68); chk("t2_e68_state", seq_state, 5);
                 chk("t2_e68_err",   seq_err, 1);
                 chk("t2_e68_rsts",  rsts(), 3'b111);
    wait_to(70); chk("t2_e70_state", seq_state, 5);

    // ---- Test 5: sw_rst_req in ERR, then lock present -> RUN
    pll_locked = 1'b1;
    wait_to(75);
    sw_rst_req = 1'b1;
    step();  // E76 is the pulse edge
    sw_rst_req = 1'b0;
    chk("t5_p_state", seq_state, 0);
    chk("t5_p_err",   seq_err, 0);
    wait_to(99);  chk("t5_e99_state",  seq_state, 3);
    wait_to(100); chk("t5_e100_state", seq_state, 4);
                  chk("t5_e100_done",  seq_done, 1);

    // ---- Test 6: lock low for 4 cycles while in RUN
    wait_to(102); pll_locked = 1'b0;
    wait_to(106); pll_locked = 1'b1;
    wait_to(107); chk("t6_e107_state", seq_state, 4);
    wait_to(108);
`ifdef RST_SEQ_WDOG_EN
    chk("t6_e108_state", seq_state, 0);
    chk("t6_e108_rsts",  rsts(), 3'b111);
    chk("t6_e108_lost",  lock_lost, 1);
    wait_to(131); chk("t6_e131_state", seq_state, 3);
    wait_to(132); chk("t6_e132_state", seq_state, 4);
                  chk("t6_e132_lost",  lock_lost, 1);
`else
    chk("t6_e108_state", seq_state, 4);
    chk("t6_e108_rsts",  rsts(), 3'b000);
    chk("t6_e108_lost",  lock_lost, 0);
    wait_to(132); chk("t6_e132_state", seq_state, 4);
                  chk("t6_e132_lost",  lock_lost, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
